// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads the synchronous instruction
// memory and buffers returned words in a 2-entry queue toward decode.
module fetch_queue #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_next
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [1:0]        r_count;
    logic              r_head;
    logic [DATA_W-1:0] r_q_instr [2];
    logic [ADDR_W-1:0] r_q_pc    [2];

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_tail;
    logic [2:0]        w_occ;

    assign id_valid = (r_count != 2'd0);
    assign w_pop    = id_valid & id_ready;
    assign w_tail   = r_head ^ r_count[0];

    // Slots already claimed once this cycle's pop retires; never exceeds 2.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = ST_RUN;
        w_push      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN:   w_push = r_inflight;
            ST_FLUSH: w_push = 1'b0;
            default:  w_push = 1'b0;
        endcase
        // NOTE: reset_n gates the combinational request so no read escapes while held in reset.
        if (reset_n && !redirect_valid)
            w_issue = (w_occ < 3'd2);
        if (redirect_valid) begin
            w_push      = 1'b0;
            w_state_nxt = ST_FLUSH;
        end
    end

    assign imem_addr  = r_fetch_pc;
    assign imem_rd_en = w_issue;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue)
                r_inflight_pc <= r_fetch_pc;
            if (redirect_valid)
                r_fetch_pc <= redirect_pc;
            else if (w_issue)
                r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            if (redirect_valid) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
            end else begin
                if (w_pop)
                    r_head <= ~r_head;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // NOTE: queue storage is not reset; outputs are masked by id_valid instead.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_instr[w_tail] <= imem_data;
            r_q_pc[w_tail]    <= r_inflight_pc;
        end
    end

    assign id_instr   = id_valid ? r_q_instr[r_head] : '0;
    assign id_pc      = id_valid ? r_q_pc[r_head]    : '0;
    assign id_pc_next = id_pc + ADDR_W'(1);

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_push && !w_pop && r_count == 2'd2));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory model plus an expected-PC scoreboard
// compared on every decode handshake.
module tb_fetch_queue;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_next;

    fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_next     (id_pc_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [ADDR_W-1:0] exp_q [$];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {8'hC3, 2'b10, a, 2'b01, ~a};
    endfunction

    // Synchronous memory: one-cycle latency, poison data when not read.
    always @(posedge clock)
        imem_data <= imem_rd_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [ADDR_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++)
            exp_q.push_back(start + ADDR_W'(i));
    endtask

    // Handshake monitor and head-stability check while stalled.
    logic              prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_pc;
    logic [DATA_W-1:0] prev_instr;

    always @(negedge clock) begin
        logic [ADDR_W-1:0] e;
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(id_valid), 32'd1);
                check("hold_pc",    32'(id_pc),    32'(prev_pc));
                check("hold_instr", id_instr,      prev_instr);
            end
            if (id_valid && id_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("pc",      32'(id_pc),      32'(e));
                check("instr",   id_instr,        mem_word(e));
                check("pc_next", 32'(id_pc_next), 32'(ADDR_W'(e + ADDR_W'(1))));
                n_pops++;
            end
            prev_hold  = id_valid && !id_ready && !redirect_valid;
            prev_pc    = id_pc;
            prev_instr = id_instr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle redirect; returns in cycle R+1 after the request is dropped.
    task automatic redirect(input logic [ADDR_W-1:0] pc, input logic rdy);
        @(posedge clock);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        id_ready       = rdy;
        @(negedge clock);
        check("redir_rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clock);
        sb_restart(pc);
        #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
    endtask

    // From cycle R+1: issue at the target, then first id_valid at R+3.
    task automatic expect_restart(input logic [ADDR_W-1:0] pc, input int lat);
        int n;
        n = 1;
        @(negedge clock);
        check("restart_rd_en", 32'(imem_rd_en), 32'd1);
        check("restart_addr",  32'(imem_addr),  32'(pc));
        while (!id_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("restart_lat", 32'(n),     32'(lat));
        check("restart_pc",  32'(id_pc), 32'(pc));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int p0;
        reset_n        = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_valid",   32'(id_valid),   32'd0);
        check("rst_rd_en",   32'(imem_rd_en), 32'd0);
        check("rst_pc",      32'(id_pc),      32'd0);
        check("rst_pc_next", 32'(id_pc_next), 32'd1);
        check("rst_instr",   id_instr,        32'd0);
        sb_restart('0);

        // Release: issue in the release cycle, head visible two edges later
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("issue_rd_en", 32'(imem_rd_en), 32'd1);
        check("issue_addr",  32'(imem_addr),  32'd0);
        edges = 0;
        while (!id_valid && edges < 10) begin
            @(negedge clock);
            edges++;
        end
        check("first_valid_lat", 32'(edges), 32'd2);

        // Backpressure cycles 5..12
        repeat (3) tick();
        id_ready = 1'b0;
        repeat (7) tick();
        @(negedge clock);
        check("full_valid", 32'(id_valid),   32'd1);
        check("full_rd_en", 32'(imem_rd_en), 32'd0);
        check("full_depth", 32'(ADDR_W'(imem_addr - id_pc)), 32'd2);
        tick();
        id_ready = 1'b1;
        p0 = n_pops;
        @(negedge clock);
        check("resume_rd_en", 32'(imem_rd_en), 32'd1);
        repeat (5) @(negedge clock);
        #1;
        check("resume_pops", 32'(n_pops - p0), 32'd6);

        // Redirect with an entry queued and a read in flight
        redirect(10'h200, 1'b0);
        expect_restart(10'h200, 3);
        repeat (4) tick();

        // Redirect coincident with a pop of a full queue, then re-redirect in FLUSH
        id_ready = 1'b0;
        repeat (3) tick();
        @(posedge clock);
        #1;
        p0             = n_pops;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h100;
        id_ready       = 1'b1;
        @(negedge clock);
        #1;
        check("redir_pop",   32'(n_pops - p0), 32'd1);
        check("redir_rd_en", 32'(imem_rd_en),  32'd0);
        @(posedge clock);
        sb_restart(10'h100);
        #1;
        redirect_pc = 10'h300;
        @(negedge clock);
        check("flush_redir_rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clock);
        sb_restart(10'h300);
        #1;
        redirect_valid = 1'b0;
        expect_restart(10'h300, 3);
        repeat (3) tick();

        // Wrap through 1023 -> 0
        redirect(10'd1022, 1'b1);
        expect_restart(10'd1022, 3);
        p0 = n_pops;
        repeat (5) @(negedge clock);
        #1;
        check("wrap_pops", 32'(n_pops - p0), 32'd5);

        // Reset mid-stream with a full queue
        tick();
        id_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(id_valid),   32'd0);
        check("mr_rd_en", 32'(imem_rd_en), 32'd0);
        sb_restart('0);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        id_ready = 1'b1;
        expect_restart('0, 3);
        p0 = n_pops;
        repeat (4) @(negedge clock);
        #1;
        check("mr_pops", 32'(n_pops - p0), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
